// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/halfword/word load-store initiator with read-modify-write sub-word stores
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [1:0]            reqSize,
  input  logic                  reqSigned,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [31:0]           reqWData,
  output logic                  respValid,
  output logic [31:0]           respData,
  output logic                  respError,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [31:0]           memWriteData,
  output logic                  memWrite,
  output logic                  memRead,
  input  logic [31:0]           memReadData
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic                    r_write;
  logic [1:0]              r_size;
  logic                    r_signed;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_old;
  logic [31:0]             r_resp_data;
  logic                    r_resp_err;

  logic                    w_req_err;
  logic [31:0]             w_lane;
  logic [31:0]             w_load_data;
  logic [31:0]             w_merged;

  // Alignment / size legality of the request being offered.
  assign w_req_err = (reqSize == 2'b11) ||
                     ((reqSize == 2'b01) && reqAddr[0]) ||
                     ((reqSize == 2'b10) && (reqAddr[1:0] != 2'b00));

  // Selected lane shifted down to bit 0; halfwords are aligned so 8*addr[1:0] == 16*addr[1].
  assign w_lane = memReadData >> {r_addr[1:0], 3'b000};

  // Load extraction with sign or zero extension.
  always_comb begin
    w_load_data = memReadData;
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load_data = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default: w_load_data = memReadData;
    endcase
  end

  // Store word: old word with the target lane replaced, or the full store data for words.
  always_comb begin
    w_merged = r_old;
    case (r_size)
      2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  assign memAddress   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign memWriteData = w_merged;
  assign respData     = r_resp_data;
  assign respError    = r_resp_err;

  // State register; reset returns to IDLE so the decoded enables drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and decoded handshake / memory enables.
  always_comb begin
    w_next    = r_state;
    reqReady  = 1'b0;
    respValid = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    case (r_state)
      S_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          if (w_req_err)                         w_next = S_RESP;
          else if (reqWrite && reqSize == 2'b10) w_next = S_WRITE;
          else                                   w_next = S_READ;
        end
      end
      S_READ: begin
        memRead = 1'b1;
        w_next  = r_write ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        memWrite = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP: begin
        respValid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, old-word capture and response registers (updated only when heading into RESP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_old       <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (reqValid) begin
            r_write  <= reqWrite;
            r_size   <= reqSize;
            r_signed <= reqSigned;
            r_addr   <= reqAddr;
            r_wdata  <= reqWData;
            if (w_req_err) begin
              r_resp_data <= '0;
              r_resp_err  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (r_write) begin
            r_old <= memReadData;
          end else begin
            r_resp_data <= w_load_data;
            r_resp_err  <= 1'b0;
          end
        end
        S_WRITE: begin
          r_resp_data <= '0;
          r_resp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a byte-array reference model
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;

  int n_checks = 0;
  int n_errors = 0;
  int both_en  = 0;
  logic clr_mem;

  logic [31:0] dmem [0:63];
  logic [7:0]  ref_mem [0:255];

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWData(reqWData),
    .respValid(respValid), .respData(respData), .respError(respError),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWrite(memWrite), .memRead(memRead), .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory: combinational read, write on rising edge.
  assign memReadData = dmem[memAddress[7:2]];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
    end else if (memWrite) begin
      dmem[memAddress[7:2]] <= memWriteData;
    end
  end

  // Enables must never overlap.
  always @(negedge clk) begin
    if (memRead && memWrite) both_en <= both_en + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input int a);
    logic [31:0] v;
    case (sz)
      2'b00: begin
        v = {24'h0, ref_mem[a]};
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = {16'h0, ref_mem[a+1], ref_mem[a]};
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endcase
    return v;
  endfunction

  // Offer one request, wait for its response; lat counts cycles from the acceptance edge.
  task automatic drive(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic re,
                       output int lat, output logic en);
    bit got;
    @(negedge clk);
    check("ready_before_req", {31'h0, reqReady}, 32'd1);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWData = wd;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0; en = 1'b0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (memRead || memWrite) en = 1'b1;
      if (respValid) got = 1'b1;
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    rd = respData;
    re = respError;
  endtask

  // Full request with model-derived expectations; updates the reference on successful stores.
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input int a, input logic [31:0] wd, output logic [31:0] rd);
    logic re, en, exp_err;
    int lat, exp_lat;
    logic [31:0] exp_data;
    exp_err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    if (exp_err)                 exp_lat = 1;
    else if (!w || sz == 2'd2)   exp_lat = 2;
    else                         exp_lat = 3;
    exp_data = (exp_err || w) ? 32'h0 : ref_load(sz, sg, a);
    drive(w, sz, sg, a, wd, rd, re, lat, en);
    check({tag, "_data"}, rd, exp_data);
    check({tag, "_err"},  {31'h0, re}, {31'h0, exp_err});
    check({tag, "_lat"},  lat, exp_lat);
    if (exp_err) check({tag, "_no_mem"}, {31'h0, en}, 32'd0);
    if (w && !exp_err) begin
      ref_mem[a] = wd[7:0];
      if (sz != 2'd0) ref_mem[a+1] = wd[15:8];
      if (sz == 2'd2) begin
        ref_mem[a+2] = wd[23:16];
        ref_mem[a+3] = wd[31:24];
      end
    end
  endtask

  initial begin
    logic [31:0] rd, r;
    int acc, resp;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    reqValid = 0; reqWrite = 0; reqSize = 0; reqSigned = 0; reqAddr = 0; reqWData = 0;
    rst_n = 1'b0; clr_mem = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, reqReady}, 32'd1);
    check("rst_resp_valid", {31'h0, respValid}, 32'd0);
    check("rst_resp_data", respData, 32'd0);
    check("rst_resp_err", {31'h0, respError}, 32'd0);
    check("rst_mem_en", {30'h0, memRead, memWrite}, 32'd0);
    check("rst_mem_addr", memAddress, 32'd0);
    check("rst_mem_wdata", memWriteData, 32'd0);
    rst_n = 1'b1; clr_mem = 1'b0;

    // 1: word store then load
    run_req("t1_st", 1, 2'd2, 0, 'h28, 32'h1234_5678, rd);
    run_req("t1_ld", 0, 2'd2, 0, 'h28, 32'h0, rd);
    check("t1_ld_const", rd, 32'h1234_5678);
    // 2: byte store
    run_req("t2_st", 1, 2'd0, 0, 'h29, 32'hAB, rd);
    run_req("t2_ldw", 0, 2'd2, 0, 'h28, 32'h0, rd);
    check("t2_ldw_const", rd, 32'h1234_AB78);
    run_req("t2_ldbs", 0, 2'd0, 1, 'h29, 32'h0, rd);
    check("t2_ldbs_const", rd, 32'hFFFF_FFAB);
    run_req("t2_ldbu", 0, 2'd0, 0, 'h29, 32'h0, rd);
    check("t2_ldbu_const", rd, 32'h0000_00AB);
    // 3: halfword store
    run_req("t3_st", 1, 2'd1, 0, 'h2A, 32'hBEEF, rd);
    run_req("t3_ldw", 0, 2'd2, 0, 'h28, 32'h0, rd);
    check("t3_ldw_const", rd, 32'hBEEF_AB78);
    run_req("t3_ldhs", 0, 2'd1, 1, 'h2A, 32'h0, rd);
    check("t3_ldhs_const", rd, 32'hFFFF_BEEF);
    run_req("t3_ldhu", 0, 2'd1, 0, 'h28, 32'h0, rd);
    check("t3_ldhu_const", rd, 32'h0000_AB78);
    // 4: error requests
    run_req("t4_wmis", 0, 2'd2, 0, 'h2A, 32'h0, rd);
    run_req("t4_hmis", 1, 2'd1, 0, 'h29, 32'h1111, rd);
    run_req("t4_ill", 0, 2'd3, 0, 'h28, 32'h0, rd);
    run_req("t4_ldw", 0, 2'd2, 0, 'h28, 32'h0, rd);
    check("t4_unchanged", rd, 32'hBEEF_AB78);

    // 5: reset during the WRITE cycle of a byte store
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqSigned = 1'b0; reqAddr = 'h28; reqWData = 32'h55;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_in_write", {31'h0, memWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_wr_drop", {31'h0, memWrite}, 32'd0);
    check("t5_no_resp", {31'h0, respValid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (respValid) resp++;
    end
    check("t5_resp_count", resp, 0);
    check("t5_ready", {31'h0, reqReady}, 32'd1);
    run_req("t5_ldw", 0, 2'd2, 0, 'h28, 32'h0, rd);
    check("t5_unchanged", rd, 32'hBEEF_AB78);

    // 6: reqValid held high for 10 cycles
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'd2; reqSigned = 1'b0; reqAddr = 'h28; reqWData = 0;
    acc = 0; resp = 0;
    for (int i = 0; i < 10; i++) begin
      if (reqReady) acc++;
      if (respValid) begin
        resp++;
        check("t6_data", respData, 32'hBEEF_AB78);
      end
      if (memRead || respValid) check("t6_busy_ready", {31'h0, reqReady}, 32'd0);
      @(negedge clk);
    end
    reqValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (respValid) resp++;
      @(negedge clk);
    end
    check("t6_accepts", acc, 4);
    check("t6_resps", resp, acc);

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      run_req("rnd", r[0], r[2:1], r[3], int'(r[9:4]), $urandom, rd);
    end
    // Random results cross-checked through word readback of every touched word
    for (int a = 0; a < 64; a += 4) run_req("rdbk", 0, 2'd2, 0, a, 32'h0, rd);

    check("no_overlap_en", both_en, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
